// File: rtl/usb_tx_byte_sequencer.sv
// usb_tx_byte_sequencer
//
// Byte-level sequencer for the USB transmit path. Takes packet bytes from a
// valid/ready stream, sends the SYNC byte first, and bit-reverses each byte so
// the PISO's MSB-first shifting puts bits on the wire LSB-first. It generates
// the PISO bit-rate shift strobe and frames the packet end with SE0 then J.
// NRZI encoding and bit stuffing happen downstream.
//
// Ports:
//   clk               system clock
//   RST               asynchronous reset, active-high
//   in_valid          packet byte presented
//   in_data[7:0]      packet byte, logical LSB-first
//   in_last           byte is the last of the packet (qualified by in_valid)
//   in_ready          byte accepted this cycle (combinational, done cycle only)
//   piso_load         PISO load strobe, registered 1-cycle pulse
//   piso_data[7:0]    bit-reversed byte for the PISO, registered
//   piso_shift_enable PISO shift strobe, one per bit time
//   piso_busy         PISO is shifting
//   piso_done         PISO done pulse, one cycle after the 8th shift
//   tx_active         packet start through the end of the EOP J bit
//   eop_se0           line driver forces SE0
//   underrun_err      1-cycle pulse when a mid-packet byte is missing

module usb_tx_byte_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       piso_load,
    output logic [7:0] piso_data,
    output logic       piso_shift_enable,
    input  logic       piso_busy,
    input  logic       piso_done,
    output logic       tx_active,
    output logic       eop_se0,
    output logic       underrun_err
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);
    localparam int unsigned BW = $clog2(EOP_SE0_BITS + 1);
    localparam logic [BW-1:0] SE0_LAST = BW'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        LAST_BIT,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   tick_cnt, tick_d;
    logic [BW-1:0]   se0_bits, se0_bits_d;
    logic            last_sent, last_sent_d;
    logic            load_d, tx_d, se0_d, ur_d;
    logic [7:0]      data_d;
    logic            tick_wrap;

    function automatic logic [7:0] reverse8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    assign tick_wrap = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            se0_bits     <= '0;
            last_sent    <= 1'b0;
            piso_load    <= 1'b0;
            piso_data    <= '0;
            tx_active    <= 1'b0;
            eop_se0      <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            state        <= state_d;
            tick_cnt     <= tick_d;
            se0_bits     <= se0_bits_d;
            last_sent    <= last_sent_d;
            piso_load    <= load_d;
            piso_data    <= data_d;
            tx_active    <= tx_d;
            eop_se0      <= se0_d;
            underrun_err <= ur_d;
        end
    end

    always_comb begin
        state_d           = state;
        last_sent_d       = last_sent;
        se0_bits_d        = '0;
        load_d            = 1'b0;
        data_d            = piso_data;
        tx_d              = tx_active;
        se0_d             = eop_se0;
        ur_d              = 1'b0;
        in_ready          = 1'b0;
        // Tick counter free-runs outside IDLE so bit timing stays continuous
        // across byte handovers and into the EOP.
        tick_d            = (state == IDLE || tick_wrap) ? '0 : tick_cnt + 1'b1;
        piso_shift_enable = (state == SYNC || state == DATA) && piso_busy && tick_wrap;

        case (state)
            IDLE: begin
                if (in_valid && !piso_busy) begin
                    state_d = SYNC;
                    load_d  = 1'b1;
                    data_d  = reverse8(SYNC_BYTE);
                    tx_d    = 1'b1;
                end
            end
            SYNC, DATA: begin
                if (piso_done) begin
                    if (last_sent) begin
                        state_d = LAST_BIT;
                    end else if (in_valid) begin
                        in_ready    = 1'b1;
                        load_d      = 1'b1;
                        data_d      = reverse8(in_data);
                        last_sent_d = in_last;
                        state_d     = DATA;
                    end else begin
                        ur_d        = 1'b1;
                        last_sent_d = 1'b1;
                        state_d     = LAST_BIT;
                    end
                end
            end
            LAST_BIT: begin
                // No shift here: the final wire bit stays on the line a full bit time.
                if (tick_wrap) begin
                    se0_d   = 1'b1;
                    state_d = EOP_SE0;
                end
            end
            EOP_SE0: begin
                se0_bits_d = se0_bits;
                if (tick_wrap) begin
                    if (se0_bits == SE0_LAST) begin
                        se0_bits_d = '0;
                        se0_d      = 1'b0;
                        state_d    = EOP_J;
                    end else begin
                        se0_bits_d = se0_bits + 1'b1;
                    end
                end
            end
            EOP_J: begin
                if (tick_wrap) begin
                    tx_d        = 1'b0;
                    last_sent_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_byte_sequencer.sv
`timescale 1ns/1ps
module tb_usb_tx_byte_sequencer;

    localparam int NA = 4, SA = 2, NB = 8, SB = 3;
    localparam logic [7:0] SYNC = 8'h80;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    // Instance A: CLKS_PER_BIT=4, EOP_SE0_BITS=2
    logic       in_valid = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, piso_load, piso_shift_enable, tx_active, eop_se0, underrun_err;
    logic [7:0] piso_data;
    logic       piso_busy, piso_done, serial_out;

    // Instance B: CLKS_PER_BIT=8, EOP_SE0_BITS=3
    logic       in_valid_b = 1'b0, in_last_b = 1'b0;
    logic [7:0] in_data_b = '0;
    logic       in_ready_b, load_b, shen_b, tx_active_b, eop_se0_b, underrun_b;
    logic [7:0] data_b;
    logic       busy_b, done_b, ser_b;

    usb_tx_byte_sequencer #(.CLKS_PER_BIT(NA), .SYNC_BYTE(SYNC), .EOP_SE0_BITS(SA)) dut_a (
        .clk(clk), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .piso_load(piso_load), .piso_data(piso_data),
        .piso_shift_enable(piso_shift_enable), .piso_busy(piso_busy), .piso_done(piso_done),
        .tx_active(tx_active), .eop_se0(eop_se0), .underrun_err(underrun_err)
    );

    usb_tx_byte_sequencer #(.CLKS_PER_BIT(NB), .SYNC_BYTE(SYNC), .EOP_SE0_BITS(SB)) dut_b (
        .clk(clk), .RST(RST), .in_valid(in_valid_b), .in_data(in_data_b), .in_last(in_last_b),
        .in_ready(in_ready_b), .piso_load(load_b), .piso_data(data_b),
        .piso_shift_enable(shen_b), .piso_busy(busy_b), .piso_done(done_b),
        .tx_active(tx_active_b), .eop_se0(eop_se0_b), .underrun_err(underrun_b)
    );

    // Behavioural 8-bit MSB-first PISO for each instance
    logic [7:0] sr_a, sr_b;
    logic [3:0] cnt_a, cnt_b;
    always @(posedge clk or posedge RST) begin
        if (RST) begin
            sr_a <= '0; cnt_a <= '0; piso_busy <= 1'b0; piso_done <= 1'b0; serial_out <= 1'b0;
        end else begin
            piso_done <= 1'b0;
            if (piso_load) begin
                sr_a <= piso_data; cnt_a <= '0; piso_busy <= 1'b1;
            end else if (piso_shift_enable && piso_busy) begin
                serial_out <= sr_a[7];
                sr_a <= {sr_a[6:0], 1'b0};
                cnt_a <= cnt_a + 4'd1;
                if (cnt_a == 4'd7) begin piso_busy <= 1'b0; piso_done <= 1'b1; end
            end
        end
    end
    always @(posedge clk or posedge RST) begin
        if (RST) begin
            sr_b <= '0; cnt_b <= '0; busy_b <= 1'b0; done_b <= 1'b0; ser_b <= 1'b0;
        end else begin
            done_b <= 1'b0;
            if (load_b) begin
                sr_b <= data_b; cnt_b <= '0; busy_b <= 1'b1;
            end else if (shen_b && busy_b) begin
                ser_b <= sr_b[7];
                sr_b <= {sr_b[6:0], 1'b0};
                cnt_b <= cnt_b + 4'd1;
                if (cnt_b == 4'd7) begin busy_b <= 1'b0; done_b <= 1'b1; end
            end
        end
    end

    // Observation: wire bits captured the cycle after each shift strobe, plus
    // cycle stamps of framing edges, handshakes and underrun pulses.
    int cyc = 0;
    bit p_sh = 0, p_se0 = 0, p_tx = 0;
    bit q_bits[$];
    int q_bstamp[$], q_se0r[$], q_se0f[$], q_txr[$], q_txf[$], q_rdy[$], q_ur[$];
    int rdy_bad = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (p_sh) begin q_bits.push_back(serial_out); q_bstamp.push_back(cyc); end
        p_sh <= piso_shift_enable;
        if (eop_se0 && !p_se0) q_se0r.push_back(cyc);
        if (!eop_se0 && p_se0) q_se0f.push_back(cyc);
        if (tx_active && !p_tx) q_txr.push_back(cyc);
        if (!tx_active && p_tx) q_txf.push_back(cyc);
        if (in_ready) begin
            q_rdy.push_back(cyc);
            if (!piso_done) rdy_bad <= rdy_bad + 1;
        end
        if (underrun_err) q_ur.push_back(cyc);
        p_se0 <= eop_se0;
        p_tx  <= tx_active;
    end

    bit pb_sh = 0, pb_se0 = 0, pb_tx = 0;
    bit qb_bits[$];
    int qb_bstamp[$], qb_se0r[$], qb_se0f[$], qb_txf[$];
    int rdy_b = 0, ur_b = 0;
    always @(negedge clk) begin
        if (pb_sh) begin qb_bits.push_back(ser_b); qb_bstamp.push_back(cyc); end
        pb_sh <= shen_b;
        if (eop_se0_b && !pb_se0) qb_se0r.push_back(cyc);
        if (!eop_se0_b && pb_se0) qb_se0f.push_back(cyc);
        if (!tx_active_b && pb_tx) qb_txf.push_back(cyc);
        if (in_ready_b) rdy_b <= rdy_b + 1;
        if (underrun_b) ur_b <= ur_b + 1;
        pb_se0 <= eop_se0_b;
        pb_tx  <= tx_active_b;
    end

    // Stimulus description and reference model
    logic [7:0] pkt_q[$];
    bit         last_q[$];
    bit         exp_bits[$];
    int         exp_plen[$];
    int s_b, s_se0r, s_se0f, s_txr, s_txf, s_rdy, s_ur, s_bad;

    task automatic take_snap();
        s_b = q_bits.size(); s_se0r = q_se0r.size(); s_se0f = q_se0f.size();
        s_txr = q_txr.size(); s_txf = q_txf.size(); s_rdy = q_rdy.size();
        s_ur = q_ur.size(); s_bad = rdy_bad;
    endtask

    // Wire image: each packet is SYNC then its bytes, all LSB-first. A packet
    // whose final byte is not marked last ends by underrun.
    task automatic build_model(output int npk, output int nur);
        bit open;
        int len;
        open = 0; len = 0; npk = 0; nur = 0;
        exp_bits.delete(); exp_plen.delete();
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (!open) begin
                for (int k = 0; k < 8; k++) exp_bits.push_back(bit'((SYNC >> k) & 8'd1));
                open = 1; len = 8;
            end
            for (int k = 0; k < 8; k++) exp_bits.push_back(bit'((pkt_q[i] >> k) & 8'd1));
            len += 8;
            if (last_q[i]) begin exp_plen.push_back(len); npk++; open = 0; end
        end
        if (open) begin exp_plen.push_back(len); npk++; nur++; end
    endtask

    task automatic offer(input bit sel, input logic [7:0] d, input logic l, output bit ok);
        bit hs;
        hs = 0;
        if (sel) begin in_valid_b = 1'b1; in_data_b = d; in_last_b = l; end
        else begin in_valid = 1'b1; in_data = d; in_last = l; end
        for (int w = 0; w < 3000 && !hs; w++) begin
            @(negedge clk);
            hs = sel ? in_ready_b : in_ready;
            @(posedge clk); #1;
        end
        ok = hs;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL handshake: in_ready stayed 0, required 1 within 3000 cycles");
        end
    endtask

    task automatic run_queue(input bit sel);
        bit ok;
        for (int i = 0; i < pkt_q.size(); i++) begin
            offer(sel, pkt_q[i], last_q[i], ok);
            if (!ok) break;
        end
        if (sel) begin in_valid_b = 1'b0; in_last_b = 1'b0; in_data_b = '0; end
        else begin in_valid = 1'b0; in_last = 1'b0; in_data = '0; end
    endtask

    task automatic wait_txf(input bit sel, input int target);
        bit done;
        done = 0;
        for (int w = 0; w < 5000 && !done; w++) begin
            @(posedge clk); #1;
            done = ((sel ? qb_txf.size() : q_txf.size()) >= target);
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL tx_end_timeout: tx_active falls got %0d, required %0d", sel ? qb_txf.size() : q_txf.size(), target);
        end
    endtask

    task automatic check_run(input string nm);
        int npk, nur, nb, idx, base, len, d, v;
        bit ok_bits;
        build_model(npk, nur);
        n_tests++;
        if (q_txf.size() - s_txf !== npk) begin
            n_fail++;
            $display("FAIL %s packets: tx_active falls got %0d, required %0d", nm, q_txf.size() - s_txf, npk);
        end
        nb = q_bits.size() - s_b;
        ok_bits = (nb == exp_bits.size());
        n_tests++;
        if (!ok_bits) begin
            n_fail++;
            $display("FAIL %s bit_count: got %0d, required %0d", nm, nb, exp_bits.size());
        end else begin
            idx = -1;
            for (int i = 0; i < nb; i++) if (idx < 0 && q_bits[s_b + i] !== exp_bits[i]) idx = i;
            n_tests++;
            if (idx >= 0) begin
                n_fail++;
                $display("FAIL %s wire_bit[%0d]: got %0d, required %0d", nm, idx, q_bits[s_b + idx], exp_bits[idx]);
            end
        end
        n_tests++;
        if (q_rdy.size() - s_rdy !== pkt_q.size()) begin
            n_fail++;
            $display("FAIL %s in_ready_pulses: got %0d, required %0d", nm, q_rdy.size() - s_rdy, pkt_q.size());
        end
        n_tests++;
        if (rdy_bad - s_bad !== 0) begin
            n_fail++;
            $display("FAIL %s ready_without_done: got %0d, required 0", nm, rdy_bad - s_bad);
        end
        n_tests++;
        if (q_ur.size() - s_ur !== nur) begin
            n_fail++;
            $display("FAIL %s underrun_cycles: got %0d, required %0d", nm, q_ur.size() - s_ur, nur);
        end
        n_tests++;
        if (ok_bits && q_se0r.size() - s_se0r == npk && q_se0f.size() - s_se0f == npk && q_txf.size() - s_txf == npk) begin
            base = s_b;
            for (int j = 0; j < npk; j++) begin
                len = exp_plen[j];
                d = 0;
                for (int i = 1; i < len; i++) begin
                    v = q_bstamp[base + i] - q_bstamp[base + i - 1];
                    if (d == 0 && v != NA) d = v;
                end
                n_tests++;
                if (d != 0) begin n_fail++; $display("FAIL %s bit_spacing pkt%0d: got %0d cycles, required %0d", nm, j, d, NA); end
                v = q_se0r[s_se0r + j] - q_bstamp[base + len - 1];
                n_tests++;
                if (v != NA) begin n_fail++; $display("FAIL %s last_bit_hold pkt%0d: got %0d, required %0d", nm, j, v, NA); end
                v = q_se0f[s_se0f + j] - q_se0r[s_se0r + j];
                n_tests++;
                if (v != SA * NA) begin n_fail++; $display("FAIL %s se0_len pkt%0d: got %0d, required %0d", nm, j, v, SA * NA); end
                v = q_txf[s_txf + j] - q_se0f[s_se0f + j];
                n_tests++;
                if (v != NA) begin n_fail++; $display("FAIL %s j_len pkt%0d: got %0d, required %0d", nm, j, v, NA); end
                base += len;
            end
        end else begin
            n_fail++;
            $display("FAIL %s eop_framing: se0 rises got %0d falls got %0d, required %0d each", nm, q_se0r.size() - s_se0r, q_se0f.size() - s_se0f, npk);
        end
    endtask

    task automatic test_reset();
        logic [14:0] oa, ob;
        repeat (2) @(posedge clk);
        #1;
        oa = {in_ready, piso_load, piso_data, piso_shift_enable, tx_active, eop_se0, underrun_err};
        ob = {in_ready_b, load_b, data_b, shen_b, tx_active_b, eop_se0_b, underrun_b};
        n_tests++;
        if (oa !== '0) begin n_fail++; $display("FAIL reset_outputs_a: got %h, required 0", oa); end
        n_tests++;
        if (ob !== '0) begin n_fail++; $display("FAIL reset_outputs_b: got %h, required 0", ob); end
        RST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        oa = {in_ready, piso_load, piso_data, piso_shift_enable, tx_active, eop_se0, underrun_err};
        n_tests++;
        if (oa !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h, required 0", oa); end
    endtask

    task automatic test_single();
        pkt_q = '{8'hA5}; last_q = '{1'b1};
        take_snap();
        run_queue(0);
        wait_txf(0, s_txf + 1);
        check_run("single_a5");
    endtask

    task automatic test_back_to_back();
        pkt_q = '{8'h01, 8'h02, 8'h03}; last_q = '{1'b0, 1'b0, 1'b1};
        take_snap();
        run_queue(0);
        wait_txf(0, s_txf + 1);
        check_run("back_to_back");
    endtask

    task automatic test_underrun();
        int v;
        pkt_q = '{8'h55}; last_q = '{1'b0};
        take_snap();
        run_queue(0);
        wait_txf(0, s_txf + 1);
        check_run("underrun");
        n_tests++;
        if (q_ur.size() > s_ur && q_rdy.size() > s_rdy) begin
            v = q_ur[s_ur] - q_rdy[s_rdy];
            if (v != 8 * NA + 1) begin
                n_fail++;
                $display("FAIL underrun_timing: pulse %0d cycles after handshake, required %0d", v, 8 * NA + 1);
            end
        end else begin
            n_fail++;
            $display("FAIL underrun_timing: no underrun pulse or handshake seen, required one each");
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        logic [14:0] oa;
        int se0_before;
        se0_before = q_se0r.size();
        offer(0, 8'($urandom), 1'b0, ok);
        if (ok) offer(0, 8'($urandom), 1'b0, ok);
        repeat (12) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        RST = 1'b1;
        #1;
        oa = {in_ready, piso_load, piso_data, piso_shift_enable, tx_active, eop_se0, underrun_err};
        n_tests++;
        if (oa !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h, required 0", oa); end
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (q_se0r.size() !== se0_before) begin
            n_fail++;
            $display("FAIL mid_reset_no_eop: se0 rises got %0d, required %0d", q_se0r.size(), se0_before);
        end
        pkt_q = '{8'($urandom)}; last_q = '{1'b1};
        take_snap();
        run_queue(0);
        wait_txf(0, s_txf + 1);
        check_run("after_reset");
    endtask

    task automatic test_param_variant();
        int npk, nur, idx, d, v, n;
        pkt_q = '{8'($urandom), 8'($urandom)}; last_q = '{1'b0, 1'b1};
        run_queue(1);
        wait_txf(1, 1);
        build_model(npk, nur);
        n = exp_bits.size();
        n_tests++;
        if (qb_bits.size() !== n) begin
            n_fail++;
            $display("FAIL b_bit_count: got %0d, required %0d", qb_bits.size(), n);
        end else begin
            idx = -1; d = 0;
            for (int i = 0; i < n; i++) if (idx < 0 && qb_bits[i] !== exp_bits[i]) idx = i;
            for (int i = 1; i < n; i++) if (d == 0 && qb_bstamp[i] - qb_bstamp[i - 1] != NB) d = qb_bstamp[i] - qb_bstamp[i - 1];
            n_tests++;
            if (idx >= 0) begin n_fail++; $display("FAIL b_wire_bit[%0d]: got %0d, required %0d", idx, qb_bits[idx], exp_bits[idx]); end
            n_tests++;
            if (d != 0) begin n_fail++; $display("FAIL b_bit_spacing: got %0d, required %0d", d, NB); end
            n_tests++;
            if (qb_se0r.size() == 1 && qb_se0f.size() == 1 && qb_txf.size() == 1) begin
                v = qb_se0r[0] - qb_bstamp[n - 1];
                n_tests++;
                if (v != NB) begin n_fail++; $display("FAIL b_last_bit_hold: got %0d, required %0d", v, NB); end
                v = qb_se0f[0] - qb_se0r[0];
                n_tests++;
                if (v != SB * NB) begin n_fail++; $display("FAIL b_se0_len: got %0d, required %0d", v, SB * NB); end
                v = qb_txf[0] - qb_se0f[0];
                if (v != NB) begin n_fail++; $display("FAIL b_j_len: got %0d, required %0d", v, NB); end
            end else begin
                n_fail++;
                $display("FAIL b_eop_framing: se0 rises got %0d, required 1", qb_se0r.size());
            end
        end
        n_tests++;
        if (rdy_b !== 2 || ur_b !== 0) begin
            n_fail++;
            $display("FAIL b_handshakes: ready got %0d underrun got %0d, required 2 and 0", rdy_b, ur_b);
        end
    endtask

    task automatic test_valid_held();
        int bad;
        pkt_q = '{8'($urandom), 8'($urandom)}; last_q = '{1'b1, 1'b1};
        take_snap();
        run_queue(0);
        wait_txf(0, s_txf + 2);
        check_run("valid_held");
        n_tests++;
        if (q_txr.size() - s_txr >= 2 && q_txf.size() - s_txf >= 1 && q_se0r.size() - s_se0r >= 1) begin
            if (q_txr[s_txr + 1] - q_txf[s_txf] != 1) begin
                n_fail++;
                $display("FAIL restart_gap: second start %0d cycles after tx_active fell, required 1", q_txr[s_txr + 1] - q_txf[s_txf]);
            end
            bad = 0;
            for (int i = s_rdy; i < q_rdy.size(); i++)
                if (q_rdy[i] >= q_se0r[s_se0r] && q_rdy[i] < q_txr[s_txr + 1]) bad++;
            n_tests++;
            if (bad != 0) begin n_fail++; $display("FAIL ready_in_eop: got %0d pulses, required 0", bad); end
        end else begin
            n_fail++;
            $display("FAIL restart_gap: tx_active rises got %0d, required 2", q_txr.size() - s_txr);
        end
    endtask

    task automatic test_random();
        int np, nbytes;
        for (int it = 0; it < 4; it++) begin
            pkt_q.delete(); last_q.delete();
            np = $urandom_range(1, 2);
            for (int p = 0; p < np; p++) begin
                nbytes = $urandom_range(1, 3);
                for (int b = 0; b < nbytes; b++) begin
                    pkt_q.push_back(8'($urandom));
                    last_q.push_back(b == nbytes - 1);
                end
            end
            if ($urandom_range(0, 3) == 0) last_q[last_q.size() - 1] = 1'b0;
            take_snap();
            run_queue(0);
            wait_txf(0, s_txf + np);
            check_run("random");
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_reset_mid_packet();
        test_param_variant();
        test_valid_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_byte_sequencer.md
Name: usb_tx_byte_sequencer

Overview:
- Drives the 8-bit PISO shift register for the USB transmit path.
- Accepts packet bytes over a valid/ready stream and prepends the SYNC byte.
- Bit-reverses each byte so the PISO's MSB-first shifting sends bits LSB-first on the wire.
- Generates the PISO bit-rate shift strobe and sequences the EOP (SE0 then J).
- Sits between the packet/CRC logic and the PISO. NRZI encoding and bit stuffing are downstream and out of scope.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per bit time; legal range is 4 or more.
- SYNC_BYTE, 8'h80, value sent ahead of every packet, LSB-first, as wire bits 0000_0001.
- EOP_SE0_BITS, 2, length of SE0 in bit times.

Ports:
- clk  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- in_valid  in  1  a packet byte is presented.
- in_data  in  8  packet byte, logical LSB-first.
- in_last  in  1  the byte is the last in the packet; qualified by in_valid.
- in_ready  out  1  byte accepted this cycle; combinational.
- piso_load  out  1  PISO load strobe; registered, 1-cycle pulse.
- piso_data  out  8  bit-reversed byte for the PISO; registered.
- piso_shift_enable  out  1  PISO shift strobe, one per bit time; combinational from the tick counter.
- piso_busy  in  1  PISO busy.
- piso_done  in  1  PISO done pulse, one cycle after the 8th shift.
- tx_active  out  1  high from packet start through the end of EOP J; registered.
- eop_se0  out  1  line driver forces SE0; registered.
- underrun_err  out  1  1-cycle pulse when a mid-packet byte is missing; registered.

Behaviour:
- Reset (async, RST=1): state IDLE. tick_cnt=0, last_sent=0. Every registered output is 0, piso_data=0. in_ready and piso_shift_enable evaluate to 0.
- Mid-operation reset aborts immediately with no EOP. The system reset also clears the PISO.
- tick_cnt counts 0..CLKS_PER_BIT-1 in every state except IDLE and wraps. It is cleared on the IDLE exit.
- piso_shift_enable = (state is SYNC or DATA) && piso_busy && tick_cnt == CLKS_PER_BIT-1.
- States: IDLE, SYNC, DATA, LAST_BIT, EOP_SE0, EOP_J.
- IDLE, in_valid=1 (byte not consumed):
  - Next cycle: piso_load=1, piso_data=reverse(SYNC_BYTE), tx_active=1, state SYNC.
  - piso_load is only ever issued while piso_busy=0.
- SYNC/DATA, piso_done=1 and last_sent=0:
  - in_ready = in_valid, combinational, in the done cycle only.
  - On handshake: next cycle piso_load=1, piso_data=reverse(in_data), last_sent<=in_last, state DATA.
- Handover timing: tick at cycle T, done at T+1, load at T+2, PISO busy at T+3. The next tick is at T+CLKS_PER_BIT, so the serial stream has no gaps or jitter between bytes.
- SYNC/DATA, piso_done=1, last_sent=0, in_valid=0: underrun_err pulses next cycle, last_sent<=1, state LAST_BIT.
- SYNC/DATA, piso_done=1, last_sent=1: state LAST_BIT.
- LAST_BIT:
  - Waits for tick_cnt == CLKS_PER_BIT-1 with no shift, so the final bit is held a full bit time.
  - Then eop_se0=1 next cycle, state EOP_SE0.
- EOP_SE0: held EOP_SE0_BITS*CLKS_PER_BIT cycles, then eop_se0=0, state EOP_J.
- EOP_J: CLKS_PER_BIT cycles (line J), then tx_active=0, last_sent=0, state IDLE.
- A new packet is sampled at the earliest in the first IDLE cycle.
- in_ready is never high outside a done cycle, including the IDLE and EOP states.
- Simultaneous events:
  - piso_done outside SYNC/DATA is ignored.
  - in_valid during EOP is held off by the source, since in_ready=0.

Test Plan:
All scenarios instantiate the real PISO, use CLKS_PER_BIT=4 unless stated, and capture serial_out on each tick+1.
1. Single byte 8'hA5, in_last=1:
   - Wire sequence 0,0,0,0,0,0,0,1 then 1,0,1,0,0,1,0,1, each bit held exactly 4 cycles.
   - eop_se0 high 8 cycles, then 4 J cycles, then tx_active falls.
   - in_ready pulses once.
2. Bytes 8'h01, 8'h02, 8'h03 back-to-back, last on 8'h03:
   - 32 contiguous bit times, every shift_enable spaced exactly 4 cycles.
   - Three in_ready pulses, each coincident with piso_done.
3. Byte 8'h55 not last, then in_valid=0:
   - underrun_err is a 1-cycle pulse after the first data done.
   - The final bit is held 4 cycles, then the normal 2-bit SE0 and 1-bit J.
4. RST asserted in the middle of byte 2 of a 3-byte packet:
   - All outputs go to 0 in the same cycle with no EOP.
   - After release, a 1-byte packet transmits correctly.
5. CLKS_PER_BIT=8, EOP_SE0_BITS=3:
   - Bit period is 8 cycles, SE0 lasts 24 cycles and J lasts 8 cycles.
6. in_valid held high continuously across two 1-byte packets:
   - The second SYNC load occurs one cycle after tx_active falls.
   - No in_ready during EOP.
